pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage core. It drives the enable and flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Enable maps to each register's `en`; flush is ORed into each register's synchronous `rst`, which zeroes its contents and so inserts a bubble. It resolves load-use hazards, taken-branch flushes and instruction/data-memory wait states, detects data-memory timeouts, and keeps stall statistics.

## Interface
- `MEM_TIMEOUT`, default 256: consecutive data-memory stall cycles before the block halts.
- `clk` in 1: core clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `idRs1`, `idRs2` in 5 each: source registers of the instruction in ID.
- `idUsesRs1`, `idUsesRs2` in 1 each: the ID instruction actually reads that source.
- `exRd` in 5: destination register read back from ID/EX (`readRd`).
- `exMemRead` in 1: ID/EX `readMemRead`.
- `branchTaken` in 1: taken branch or jump resolved in EX this cycle.
- `imemReady` in 1: instruction fetch data valid this cycle.
- `dmemReq` in 1: MEM stage has a load or store in flight.
- `dmemReady` in 1: data memory completes the MEM-stage access this cycle.
- `pcEn`, `ifidEn`, `idexEn`, `exmemEn`, `memwbEn` out 1 each: register enables.
- `ifidFlush`, `idexFlush` out 1 each: bubble insertion.
- `memTimeout` out 1: sticky flag; set when a data-memory access times out.
- `stallCycles` out 32: count of cycles with `pcEn`=0.
- `bubbleCount` out 32: count of cycles with `idexFlush`=1.

## Operation
- All enable and flush outputs are combinational from the current state and inputs.
- FSM has three states: RUN, MEM_WAIT and HALT.
- The first matching priority rule applies each cycle. Any output not listed for a rule defaults to all enables 1 and all flushes 0.
  1. **rst=1:** all enables 0, both flushes 1.
  2. **state HALT:** all enables 0, flushes 0.
  3. **memStall = dmemReq & !dmemReady:** all enables 0, flushes 0. The whole pipe freezes; no flush is issued, even if `branchTaken`=1.
  4. **branchTaken:** all enables 1, `ifidFlush`=1, `idexFlush`=1. Any load-use hazard is ignored because the ID instruction is being flushed.
  5. **loadUse:** `pcEn`=0, `ifidEn`=0, `idexFlush`=1, `exmemEn`=`memwbEn`=1.
     - loadUse = exMemRead & exRd≠0 & ((idUsesRs1 & idRs1==exRd) | (idUsesRs2 & idRs2==exRd)).
  6. **!imemReady:** `pcEn`=0, `ifidFlush`=1, all other enables 1. A bubble enters IF/ID and downstream stages drain.
  7. **otherwise:** all enables 1, flushes 0.
- `idexEn` stays 1 whenever `idexFlush`=1.
- FSM transitions, evaluated at each edge:
  - **RUN → MEM_WAIT** on memStall; `waitCnt` loads 1.
  - **MEM_WAIT:**
    - memStall with `waitCnt`==MEM_TIMEOUT-1 → HALT; `memTimeout` set to 1.
    - memStall otherwise → stay; `waitCnt`+1.
    - !memStall → RUN; `waitCnt` cleared.
  - **HALT:** exits only on `rst`.
- Counters are 32-bit and wrap modulo 2^32. They increment at the edge closing a cycle that meets their condition. In HALT, `stallCycles` keeps counting.

## Timing
- Stall and flush decisions take effect in the same cycle as the inputs that cause them (0-cycle decode). Counters and `memTimeout` update one edge later.
- Load-use inserts exactly one bubble: next cycle `exMemRead` is 0, so the pipe resumes.
- Taken branch costs 2 bubbles: IF/ID and ID/EX are both flushed in one cycle.
- Memory handshake:
  - A `dmemReady`=1 cycle is a normal cycle that advances the pipe.
  - A `dmemReady` asserted on the same cycle as `dmemReq`'s first cycle causes no stall.
- Branch arriving during memStall: held, because EX is frozen. It is flushed on the first non-stalled cycle, where rule 4 applies.
- Timeout: `memTimeout` rises after MEM_TIMEOUT consecutive memStall cycles; HALT outputs apply from the following cycle.
- Reset values: state RUN, `waitCnt`=0, `memTimeout`=0, `stallCycles`=0, `bubbleCount`=0.
- Reset mid-MEM_WAIT or in HALT returns to RUN in one edge. While `rst`=1, outputs follow rule 1.

## Test plan
- **Load-use:** exMemRead=1, exRd=5, idRs1=5, idUsesRs1=1 for one cycle → `pcEn`=0, `ifidEn`=0, `idexFlush`=1 that cycle; `bubbleCount` 0→1; `stallCycles` 0→1.
- **No false stall:** exMemRead=1, exRd=0, idRs1=0 → all enables 1, no flush. Repeat with exRd=5, idRs2=5, idUsesRs2=0 → all enables 1, no flush.
- **Branch beats load-use:** branchTaken=1 together with a loadUse condition → `pcEn`=1, both flushes 1, `stallCycles` unchanged.
- **Memory wait:** dmemReq=1, dmemReady=0 for 3 cycles, then dmemReady=1 → all enables 0 for 3 cycles, state MEM_WAIT, `stallCycles`=3, RUN after the ready cycle. A branchTaken=1 held throughout → flushes asserted only on the ready cycle.
- **Timeout:** MEM_TIMEOUT=4, dmemReady held 0 → `memTimeout`=1 after the 4th stall edge; all enables stay 0 while `stallCycles` keeps incrementing. `rst`=1 for one cycle → RUN, all counters and `memTimeout` at 0.
- **Fetch stall:** imemReady=0 for 2 cycles, no other hazard → `pcEn`=0, `ifidFlush`=1, `idexEn`=`exmemEn`=`memwbEn`=1, `stallCycles`=2, `bubbleCount` unchanged.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage pipeline and pipeline_hazard_ctrl.
//   Hazard inputs : idRs1/idRs2, idUsesRs1/idUsesRs2, exRd, exMemRead,
//                   branchTaken, imemReady, dmemReq, dmemReady
//   Control       : pcEn, ifidEn, idexEn, exmemEn, memwbEn, ifidFlush, idexFlush
//   Status        : memTimeout, stallCycles, bubbleCount
// master = pipeline side (drives hazard inputs), slave = the controller.
interface pipeline_hazard_ctrl_if;
  logic [4:0]  idRs1;
  logic [4:0]  idRs2;
  logic        idUsesRs1;
  logic        idUsesRs2;
  logic [4:0]  exRd;
  logic        exMemRead;
  logic        branchTaken;
  logic        imemReady;
  logic        dmemReq;
  logic        dmemReady;
  logic        pcEn;
  logic        ifidEn;
  logic        idexEn;
  logic        exmemEn;
  logic        memwbEn;
  logic        ifidFlush;
  logic        idexFlush;
  logic        memTimeout;
  logic [31:0] stallCycles;
  logic [31:0] bubbleCount;

  modport master (
    output idRs1, idRs2, idUsesRs1, idUsesRs2, exRd, exMemRead,
           branchTaken, imemReady, dmemReq, dmemReady,
    input  pcEn, ifidEn, idexEn, exmemEn, memwbEn, ifidFlush, idexFlush,
           memTimeout, stallCycles, bubbleCount
  );

  modport slave (
    input  idRs1, idRs2, idUsesRs1, idUsesRs2, exRd, exMemRead,
           branchTaken, imemReady, dmemReq, dmemReady,
    output pcEn, ifidEn, idexEn, exmemEn, memwbEn, ifidFlush, idexFlush,
           memTimeout, stallCycles, bubbleCount
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core. Resolves load-use hazards,
// taken-branch flushes and instruction/data memory wait states, halts on a
// data-memory timeout and keeps stall/bubble statistics.
// Ports:
//   clk - core clock (rising edge)
//   rst - synchronous, active-high reset
//   hif - pipeline_hazard_ctrl_if.slave (hazard inputs, enables/flushes, status)
//
// state    | meaning
// RUN      | normal operation, no data-memory stall in progress
// MEM_WAIT | data-memory stall in progress, waitCnt counts stall cycles
// HALT     | data-memory timeout, pipe frozen until rst
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_hazard_ctrl_if.slave hif
);

  localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [CW-1:0] LAST_CNT = CW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  state_t        state, stateNext;
  logic [CW-1:0] waitCnt, waitCntNext;
  logic          timeoutHit;
  logic          memTimeoutQ;
  logic [31:0]   stallCyclesQ, bubbleCountQ;

  logic memStall, loadUse;
  logic pcEn, ifidEn, idexEn, exmemEn, memwbEn, ifidFlush, idexFlush;

  assign memStall = hif.dmemReq & ~hif.dmemReady;
  assign loadUse  = hif.exMemRead & (hif.exRd != 5'd0) &
                    ((hif.idUsesRs1 & (hif.idRs1 == hif.exRd)) |
                     (hif.idUsesRs2 & (hif.idRs2 == hif.exRd)));

  // Priority decode of enables/flushes; first matching rule wins.
  always_comb begin
    pcEn      = 1'b1;
    ifidEn    = 1'b1;
    idexEn    = 1'b1;
    exmemEn   = 1'b1;
    memwbEn   = 1'b1;
    ifidFlush = 1'b0;
    idexFlush = 1'b0;
    if (rst) begin
      {pcEn, ifidEn, idexEn, exmemEn, memwbEn} = 5'b0;
      ifidFlush = 1'b1;
      idexFlush = 1'b1;
    end else if (state == HALT || memStall) begin
      // Full freeze; a pending branch stays in EX and is flushed later.
      {pcEn, ifidEn, idexEn, exmemEn, memwbEn} = 5'b0;
    end else if (hif.branchTaken) begin
      // ID instruction is discarded, so any load-use on it is moot.
      ifidFlush = 1'b1;
      idexFlush = 1'b1;
    end else if (loadUse) begin
      pcEn      = 1'b0;
      ifidEn    = 1'b0;
      idexFlush = 1'b1;
    end else if (!hif.imemReady) begin
      pcEn      = 1'b0;
      ifidFlush = 1'b1;
    end
  end

  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    timeoutHit  = 1'b0;
    case (state)
      RUN: begin
        if (memStall) begin
          if (MEM_TIMEOUT <= 1) begin
            stateNext  = HALT;
            timeoutHit = 1'b1;
          end else begin
            stateNext   = MEM_WAIT;
            waitCntNext = CW'(1);
          end
        end
      end
      MEM_WAIT: begin
        if (!memStall) begin
          stateNext   = RUN;
          waitCntNext = '0;
        end else if (waitCnt == LAST_CNT) begin
          stateNext  = HALT;
          timeoutHit = 1'b1;
        end else begin
          waitCntNext = waitCnt + CW'(1);
        end
      end
      HALT:    stateNext = HALT;
      default: stateNext = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      waitCnt      <= '0;
      memTimeoutQ  <= 1'b0;
      stallCyclesQ <= 32'd0;
      bubbleCountQ <= 32'd0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
      if (timeoutHit) memTimeoutQ <= 1'b1;
      if (!pcEn)      stallCyclesQ <= stallCyclesQ + 32'd1;
      if (idexFlush)  bubbleCountQ <= bubbleCountQ + 32'd1;
    end
  end

  assign hif.pcEn        = pcEn;
  assign hif.ifidEn      = ifidEn;
  assign hif.idexEn      = idexEn;
  assign hif.exmemEn     = exmemEn;
  assign hif.memwbEn     = memwbEn;
  assign hif.ifidFlush   = ifidFlush;
  assign hif.idexFlush   = idexFlush;
  assign hif.memTimeout  = memTimeoutQ;
  assign hif.stallCycles = stallCyclesQ;
  assign hif.bubbleCount = bubbleCountQ;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4).
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  logic [31:0] expStall  = 32'd0;
  logic [31:0] expBubble = 32'd0;

  // {pcEn, ifidEn, idexEn, exmemEn, memwbEn, ifidFlush, idexFlush}
  localparam logic [6:0] V_RESET  = 7'b00000_11;
  localparam logic [6:0] V_FREEZE = 7'b00000_00;
  localparam logic [6:0] V_BRANCH = 7'b11111_11;
  localparam logic [6:0] V_LDUSE  = 7'b00111_01;
  localparam logic [6:0] V_FETCH  = 7'b01111_10;
  localparam logic [6:0] V_RUN    = 7'b11111_00;

  pipeline_hazard_ctrl_if hif ();

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .hif (hif)
  );

  always #5 clk = ~clk;

  wire [6:0] ctl = {hif.pcEn, hif.ifidEn, hif.idexEn, hif.exmemEn, hif.memwbEn,
                    hif.ifidFlush, hif.idexFlush};

  task automatic setIdle();
    hif.idRs1 = 5'd0; hif.idRs2 = 5'd0;
    hif.idUsesRs1 = 1'b0; hif.idUsesRs2 = 1'b0;
    hif.exRd = 5'd0; hif.exMemRead = 1'b0;
    hif.branchTaken = 1'b0; hif.imemReady = 1'b1;
    hif.dmemReq = 1'b0; hif.dmemReady = 1'b0;
  endtask

  task automatic setLoadUse();
    hif.exMemRead = 1'b1; hif.exRd = 5'd5;
    hif.idRs1 = 5'd5; hif.idUsesRs1 = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    setIdle();
    @(negedge clk);
    tests++;
    if (ctl !== V_RESET) begin
      fails++; $display("FAIL reset_ctl: got %b want %b", ctl, V_RESET);
    end
    @(posedge clk); #1;
    tests++;
    if (hif.stallCycles !== 32'd0 || hif.bubbleCount !== 32'd0 || hif.memTimeout !== 1'b0) begin
      fails++; $display("FAIL reset_status: got stall=%0d bubble=%0d tmo=%b want 0 0 0",
                        hif.stallCycles, hif.bubbleCount, hif.memTimeout);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (ctl !== V_RUN) begin
      fails++; $display("FAIL idle_ctl: got %b want %b", ctl, V_RUN);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_load_use();
    setLoadUse();
    @(negedge clk);
    tests++;
    if (ctl !== V_LDUSE) begin
      fails++; $display("FAIL loaduse_ctl: got %b want %b", ctl, V_LDUSE);
    end
    @(posedge clk); #1;
    expStall++; expBubble++;
    setIdle();
    tests++;
    if (hif.stallCycles !== expStall || hif.bubbleCount !== expBubble) begin
      fails++; $display("FAIL loaduse_cnt: got stall=%0d bubble=%0d want %0d %0d",
                        hif.stallCycles, hif.bubbleCount, expStall, expBubble);
    end
  endtask

  task automatic test_no_false_stall();
    hif.exMemRead = 1'b1; hif.exRd = 5'd0; hif.idRs1 = 5'd0; hif.idUsesRs1 = 1'b1;
    @(negedge clk);
    tests++;
    if (ctl !== V_RUN) begin
      fails++; $display("FAIL nofalse_x0: got %b want %b", ctl, V_RUN);
    end
    @(posedge clk); #1;
    hif.exRd = 5'd5; hif.idRs1 = 5'd3; hif.idUsesRs1 = 1'b1;
    hif.idRs2 = 5'd5; hif.idUsesRs2 = 1'b0;
    @(negedge clk);
    tests++;
    if (ctl !== V_RUN) begin
      fails++; $display("FAIL nofalse_rs2unused: got %b want %b", ctl, V_RUN);
    end
    // Same registers but rs2 now really read: must stall.
    hif.idUsesRs2 = 1'b1;
    #1;
    tests++;
    if (ctl !== V_LDUSE) begin
      fails++; $display("FAIL loaduse_rs2: got %b want %b", ctl, V_LDUSE);
    end
    @(posedge clk); #1;
    expStall++; expBubble++;
    setIdle();
    tests++;
    if (hif.stallCycles !== expStall || hif.bubbleCount !== expBubble) begin
      fails++; $display("FAIL nofalse_cnt: got stall=%0d bubble=%0d want %0d %0d",
                        hif.stallCycles, hif.bubbleCount, expStall, expBubble);
    end
  endtask

  task automatic test_branch_beats_load_use();
    setLoadUse();
    hif.branchTaken = 1'b1;
    @(negedge clk);
    tests++;
    if (ctl !== V_BRANCH) begin
      fails++; $display("FAIL branch_ctl: got %b want %b", ctl, V_BRANCH);
    end
    @(posedge clk); #1;
    expBubble++;
    setIdle();
    tests++;
    if (hif.stallCycles !== expStall || hif.bubbleCount !== expBubble) begin
      fails++; $display("FAIL branch_cnt: got stall=%0d bubble=%0d want %0d %0d",
                        hif.stallCycles, hif.bubbleCount, expStall, expBubble);
    end
  endtask

  task automatic test_mem_wait();
    hif.dmemReq = 1'b1; hif.dmemReady = 1'b0; hif.branchTaken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (ctl !== V_FREEZE) begin
        fails++; $display("FAIL memwait_ctl[%0d]: got %b want %b", i, ctl, V_FREEZE);
      end
      @(posedge clk); #1;
      expStall++;
    end
    tests++;
    if (dut.state !== 2'd1) begin
      fails++; $display("FAIL memwait_state: got %0d want 1", dut.state);
    end
    tests++;
    if (hif.stallCycles !== expStall || hif.bubbleCount !== expBubble) begin
      fails++; $display("FAIL memwait_cnt: got stall=%0d bubble=%0d want %0d %0d",
                        hif.stallCycles, hif.bubbleCount, expStall, expBubble);
    end
    hif.dmemReady = 1'b1;
    @(negedge clk);
    tests++;
    if (ctl !== V_BRANCH) begin
      fails++; $display("FAIL memready_ctl: got %b want %b", ctl, V_BRANCH);
    end
    @(posedge clk); #1;
    expBubble++;
    setIdle();
    tests++;
    if (dut.state !== 2'd0 || hif.bubbleCount !== expBubble || hif.stallCycles !== expStall) begin
      fails++; $display("FAIL memready_state: got state=%0d stall=%0d bubble=%0d want 0 %0d %0d",
                        dut.state, hif.stallCycles, hif.bubbleCount, expStall, expBubble);
    end
  endtask

  task automatic test_fetch_stall();
    hif.imemReady = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++;
      if (ctl !== V_FETCH) begin
        fails++; $display("FAIL fetch_ctl[%0d]: got %b want %b", i, ctl, V_FETCH);
      end
      @(posedge clk); #1;
      expStall++;
    end
    setIdle();
    tests++;
    if (hif.stallCycles !== expStall || hif.bubbleCount !== expBubble) begin
      fails++; $display("FAIL fetch_cnt: got stall=%0d bubble=%0d want %0d %0d",
                        hif.stallCycles, hif.bubbleCount, expStall, expBubble);
    end
  endtask

  task automatic test_back_to_back();
    // Load-use, then a single-cycle dmemReq answered immediately, then branch.
    setLoadUse();
    @(negedge clk);
    tests++;
    if (ctl !== V_LDUSE) begin
      fails++; $display("FAIL b2b_ld: got %b want %b", ctl, V_LDUSE);
    end
    @(posedge clk); #1;
    expStall++; expBubble++;
    setIdle();
    hif.dmemReq = 1'b1; hif.dmemReady = 1'b1;
    @(negedge clk);
    tests++;
    if (ctl !== V_RUN) begin
      fails++; $display("FAIL b2b_memfast: got %b want %b", ctl, V_RUN);
    end
    @(posedge clk); #1;
    setIdle();
    hif.branchTaken = 1'b1;
    @(negedge clk);
    tests++;
    if (ctl !== V_BRANCH || dut.state !== 2'd0) begin
      fails++; $display("FAIL b2b_br: got %b state=%0d want %b state=0", ctl, dut.state, V_BRANCH);
    end
    @(posedge clk); #1;
    expBubble++;
    setIdle();
    tests++;
    if (hif.stallCycles !== expStall || hif.bubbleCount !== expBubble) begin
      fails++; $display("FAIL b2b_cnt: got stall=%0d bubble=%0d want %0d %0d",
                        hif.stallCycles, hif.bubbleCount, expStall, expBubble);
    end
  endtask

  task automatic test_timeout();
    hif.dmemReq = 1'b1; hif.dmemReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if (ctl !== V_FREEZE || hif.memTimeout !== 1'b0) begin
        fails++; $display("FAIL tmo_wait[%0d]: got %b tmo=%b want %b tmo=0",
                          i, ctl, hif.memTimeout, V_FREEZE);
      end
      @(posedge clk); #1;
      expStall++;
    end
    tests++;
    if (hif.memTimeout !== 1'b1 || dut.state !== 2'd2) begin
      fails++; $display("FAIL tmo_flag: got tmo=%b state=%0d want 1 2", hif.memTimeout, dut.state);
    end
    // Memory now idle and a branch pending: HALT must still freeze.
    setIdle();
    hif.branchTaken = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++;
      if (ctl !== V_FREEZE) begin
        fails++; $display("FAIL halt_ctl[%0d]: got %b want %b", i, ctl, V_FREEZE);
      end
      @(posedge clk); #1;
      expStall++;
    end
    tests++;
    if (hif.stallCycles !== expStall || hif.bubbleCount !== expBubble) begin
      fails++; $display("FAIL halt_cnt: got stall=%0d bubble=%0d want %0d %0d",
                        hif.stallCycles, hif.bubbleCount, expStall, expBubble);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (ctl !== V_RESET) begin
      fails++; $display("FAIL halt_rst_ctl: got %b want %b", ctl, V_RESET);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    setIdle();
    expStall = 32'd0; expBubble = 32'd0;
    tests++;
    if (dut.state !== 2'd0 || hif.memTimeout !== 1'b0 ||
        hif.stallCycles !== 32'd0 || hif.bubbleCount !== 32'd0) begin
      fails++; $display("FAIL halt_rst_status: got state=%0d tmo=%b stall=%0d bubble=%0d want 0 0 0 0",
                        dut.state, hif.memTimeout, hif.stallCycles, hif.bubbleCount);
    end
    @(negedge clk);
    tests++;
    if (ctl !== V_RUN) begin
      fails++; $display("FAIL post_rst_ctl: got %b want %b", ctl, V_RUN);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_false_stall();
    test_branch_beats_load_use();
    test_mem_wait();
    test_fetch_stall();
    test_back_to_back();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
